cs_init_xchg: RTL and testbench
===============================

# cs_init_xchg

Initiator-side exchange engine for the partitioned co-simulation link, at the end opposite the target partition. On each rising edge of mission clock clk_0_h, it captures three 9-bit input vectors {wen, i_data} and pushes them over a ready/valid transport channel as slots 0..2. It then waits for the target's slot-3 response {valid, o_data} and freezes the mission clocks until that response arrives, or until a watchdog expires.

## Interface
- PAY_W, 9, payload width per slot ({wen, data[7:0]})
- WDOG_MAX, 10000, cycles without progress before timeout
- WDOG_W, 14, watchdog counter width (must hold WDOG_MAX)
- clk_i  in  1  utility clock; the only clock
- rst_i  in  1  asynchronous, active-high reset
- clk_0_h  in  1  mission clock, sampled as data in clk_i domain
- wen0/wen1/wen2  in  1  slot write enables
- i_data0/i_data1/i_data2  in  8  slot data
- tx_valid  out  1  slot payload offered
- tx_ready  in  1  transport accepts payload
- tx_idx  out  2  slot index 0..2
- tx_payload  out  PAY_W  {wenN, i_dataN}
- rx_valid  in  1  response offered
- rx_ready  out  1  high only in WAIT_RSP
- rx_idx  in  2  response index; only 3 is accepted
- rx_payload  in  PAY_W  {valid, o_data}
- freeze_clk  out  4  mission-clock hold, all bits equal
- rsp_valid  out  1  one-cycle pulse: new response registered
- rsp_data  out  8  last o_data
- rsp_flag  out  1  last valid bit
- busy  out  1  FSM not in IDLE
- err_wdog  out  1  sticky timeout flag
- err_ovr  out  1  sticky flag: clk_0_h edge dropped while busy

## Operation
- Edge detect: clk_0_h_d <= clk_0_h; rise = clk_0_h & ~clk_0_h_d, registered into edge_p.
- States: IDLE, SEND, WAIT_RSP.
- IDLE with edge_p:
  - Capture all three {wenN, i_dataN} into snap[0..2].
  - slot <= 0, freeze_clk <= 4'hF, go to SEND.
- SEND:
  - tx_valid = 1, tx_idx = slot, tx_payload = snap[slot]. Both held stable until tx_ready.
  - On handshake: slot = 2 goes to WAIT_RSP, otherwise slot++.
- WAIT_RSP:
  - rx_ready = 1.
  - rx_valid & rx_idx==3: register rsp_flag/rsp_data from rx_payload, pulse rsp_valid, freeze_clk <= 0, go to IDLE.
  - rx_valid with rx_idx != 3: consumed and dropped, no state change.
- Overrun: edge_p while not in IDLE sets err_ovr. The edge is dropped and the current transaction continues.
- Watchdog:
  - Counts cycles in SEND/WAIT_RSP.
  - Cleared on IDLE exit, on every tx handshake, and on entry to WAIT_RSP.
  - When count == WDOG_MAX: err_wdog <= 1, tx_valid drops, freeze_clk <= 0, go to IDLE, snap unchanged.
- Sticky errors clear only on rst_i.
- Reset (any time, including mid-transaction):
  - State IDLE, all outputs 0, snap/rsp registers 0.
  - clk_0_h_d <= 0, so a clk_0_h already high at release yields one edge.

## Timing
- clk_0_h rise sampled at edge k: edge_p high at k+1, capture at k+1, tx_valid high from k+2.
- With tx_ready tied high: slots 0, 1, 2 on consecutive cycles k+2, k+3, k+4; WAIT_RSP from k+5.
- Response accepted at cycle r: rsp_valid, rsp_* and freeze_clk=0 visible at r+1; IDLE at r+1.
- Earliest next capture: edge_p in the cycle the FSM is in IDLE.
- An edge_p coinciding with the response-acceptance cycle is an overrun.
- Watchdog fires on the cycle the counter reaches WDOG_MAX; outputs update the next cycle.

## Configuration
- CS_INIT_SKIP_UNCHANGED_EN defined:
  - A last_sent[0..2] register holds the last transmitted payload per slot.
  - SEND skips a slot whose snap equals last_sent; a skipped slot costs one cycle with tx_valid low.
  - If all three slots are unchanged, the FSM goes directly to WAIT_RSP.
  - last_sent resets to 0.
- Not defined: all three slots are sent on every edge, and there is no last_sent storage.

## Structure
- Package cs_xchg_pkg:
  - xchg_state_t enum (IDLE, SEND, WAIT_RSP).
  - NSLOT=3, RSP_IDX=2'd3, PAY_W default.
  - typedef cs_payload_t as logic [PAY_W-1:0].
- Sub-module cs_rise_det: clk_i/rst_i, synchronous-sample rise detector producing the registered edge_p.

## Test plan
- Edge with wen0=1/i_data0=8'hA5, others 0, tx_ready=1 → payloads 9'h1A5, 9'h000, 9'h000 on idx 0, 1, 2 at k+2..k+4; freeze_clk=4'hF.
- In WAIT_RSP, rx_idx=3 with rx_payload=9'h13C → rsp_flag=1, rsp_data=8'h3C, one rsp_valid pulse, freeze_clk=0, busy=0.
- tx_ready low for 5 cycles on slot 1 → tx_idx=1 and payload held stable throughout; slot 2 follows the handshake.
- No response with WDOG_MAX=20 → err_wdog=1 on cycle 21 of WAIT_RSP, freeze_clk=0, FSM returns to IDLE.
- Second clk_0_h edge during SEND → err_ovr=1, exactly three tx handshakes total; rx_idx=1 response ignored.
- With CS_INIT_SKIP_UNCHANGED_EN, two edges with identical inputs → second transaction issues zero tx handshakes and enters WAIT_RSP directly; rst_i asserted mid-SEND clears everything.

Source files
------------

// File: rtl/cs_xchg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cs_xchg_pkg
// Purpose  : Shared types and constants for the initiator-side co-simulation
//            exchange engine. These cover the slot count, the response index,
//            the payload width and the FSM state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package cs_xchg_pkg;

    localparam int          NSLOT   = 3;
    localparam logic [1:0]  RSP_IDX = 2'd3;
    localparam int          PAY_W   = 9;

    typedef logic [PAY_W-1:0] cs_payload_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } xchg_state_t;

endpackage
`default_nettype wire

// File: rtl/cs_init_xchg_if.sv
`default_nettype none
// ============================================================================
// Module   : cs_init_xchg_if
// Purpose  : Ready/valid transport channel between the initiator engine and
//            the link. The tx side carries slots 0..2 outward. The rx side
//            carries the target's slot-3 response inward.
// Ports    : master - initiator (drives tx_*, rx_ready)
//            slave  - transport (drives tx_ready, rx_valid/idx/payload)
// Revision : 1.0 - initial release
// ============================================================================
interface cs_init_xchg_if #(
    parameter int PAY_W = 9
) ();
    logic             tx_valid;
    logic             tx_ready;
    logic [1:0]       tx_idx;
    logic [PAY_W-1:0] tx_payload;
    logic             rx_valid;
    logic             rx_ready;
    logic [1:0]       rx_idx;
    logic [PAY_W-1:0] rx_payload;

    modport master (
        output tx_valid, tx_idx, tx_payload, rx_ready,
        input  tx_ready, rx_valid, rx_idx, rx_payload
    );

    modport slave (
        input  tx_valid, tx_idx, tx_payload, rx_ready,
        output tx_ready, rx_valid, rx_idx, rx_payload
    );
endinterface
`default_nettype wire

// File: rtl/cs_rise_det.sv
`default_nettype none
// ============================================================================
// Module   : cs_rise_det
// Purpose  : Samples a slow signal in the clk_i domain and produces a
//            registered one-cycle pulse on each rising transition. The delay
//            register clears on reset, so an input already high at reset
//            release still yields exactly one pulse.
// Ports    : clk_i, rst_i (async, active-high), din, edge_p
// Revision : 1.0 - initial release
// ============================================================================
module cs_rise_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din,
    output logic edge_p
);
    logic r_din_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_din_d <= 1'b0;
            edge_p  <= 1'b0;
        end else begin
            r_din_d <= din;
            edge_p  <= din & ~r_din_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cs_init_xchg.sv
`default_nettype none
// ============================================================================
// Module   : cs_init_xchg
// Purpose  : Initiator exchange engine. On each clk_0_h rise it snapshots the
//            three {wen, data} slots and sends them over xif.tx. It then
//            waits for the slot-3 response on xif.rx. Mission clocks stay
//            frozen until the response arrives or the watchdog expires.
// Ports    : clk_i, rst_i (async, active-high), clk_0_h, wen0..2, i_data0..2,
//            xif (master), freeze_clk, rsp_valid/rsp_data/rsp_flag, busy,
//            err_wdog, err_ovr
// Config   : CS_INIT_SKIP_UNCHANGED_EN - skip slots equal to the last payload
//            sent on that slot.
// Revision : 1.0 - initial release
// ============================================================================
module cs_init_xchg
    import cs_xchg_pkg::*;
#(
    parameter int PAY_W    = 9,
    parameter int WDOG_MAX = 10000,
    parameter int WDOG_W   = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_0_h,
    input  logic                  wen0,
    input  logic                  wen1,
    input  logic                  wen2,
    input  logic [7:0]            i_data0,
    input  logic [7:0]            i_data1,
    input  logic [7:0]            i_data2,
    cs_init_xchg_if.master        xif,
    output logic [3:0]            freeze_clk,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  rsp_flag,
    output logic                  busy,
    output logic                  err_wdog,
    output logic                  err_ovr
);
    localparam logic [1:0]        ST_IDLE     = IDLE;
    localparam logic [1:0]        ST_SEND     = SEND;
    localparam logic [1:0]        ST_WAIT     = WAIT_RSP;
    localparam logic [1:0]        C_LAST_SLOT = 2'(NSLOT - 1);
    localparam logic [WDOG_W-1:0] C_WDOG_MAX  = WDOG_W'(WDOG_MAX);

    logic                w_edge_p;
    logic [1:0]          r_state;
    logic [1:0]          r_slot;
    logic [PAY_W-1:0]    r_snap [NSLOT];
    logic [PAY_W-1:0]    w_in   [NSLOT];
    logic [WDOG_W-1:0]   r_wdog;
    logic                w_unch;
    logic                w_all_unch;
    logic                w_tx_valid;
    logic                w_hs;
    logic                w_rsp_hit;

    cs_rise_det u_rise (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din    (clk_0_h),
        .edge_p (w_edge_p)
    );

    always_comb begin
        w_in[0] = PAY_W'({wen0, i_data0});
        w_in[1] = PAY_W'({wen1, i_data1});
        w_in[2] = PAY_W'({wen2, i_data2});
    end

`ifdef CS_INIT_SKIP_UNCHANGED_EN
    logic [PAY_W-1:0] r_last [NSLOT];

    assign w_unch     = (r_snap[r_slot] == r_last[r_slot]);
    assign w_all_unch = (w_in[0] == r_last[0]) && (w_in[1] == r_last[1]) &&
                        (w_in[2] == r_last[2]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSLOT; i++) r_last[i] <= '0;
        end else if (w_hs) begin
            r_last[r_slot] <= r_snap[r_slot];
        end
    end
`else
    assign w_unch     = 1'b0;
    assign w_all_unch = 1'b0;
`endif

    // A skipped slot holds tx_valid low for its cycle.
    assign w_tx_valid     = (r_state == ST_SEND) && !w_unch;
    assign w_hs           = w_tx_valid && xif.tx_ready;
    assign w_rsp_hit      = (r_state == ST_WAIT) && xif.rx_valid && (xif.rx_idx == RSP_IDX);
    assign xif.tx_valid   = w_tx_valid;
    assign xif.tx_idx     = r_slot;
    assign xif.tx_payload = r_snap[r_slot];
    assign xif.rx_ready   = (r_state == ST_WAIT);
    assign busy           = (r_state != ST_IDLE);

    // A handshake or response counts as progress and wins over a
    // simultaneous watchdog expiry, so no accepted beat is ever lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_slot     <= 2'd0;
            r_wdog     <= '0;
            freeze_clk <= 4'h0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_flag   <= 1'b0;
            err_wdog   <= 1'b0;
            err_ovr    <= 1'b0;
            for (int i = 0; i < NSLOT; i++) r_snap[i] <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_edge_p && (r_state != ST_IDLE)) err_ovr <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (w_edge_p) begin
                        for (int i = 0; i < NSLOT; i++) r_snap[i] <= w_in[i];
                        r_slot     <= 2'd0;
                        freeze_clk <= 4'hF;
                        r_state    <= w_all_unch ? ST_WAIT : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_wdog <= '0;
                        if (r_slot == C_LAST_SLOT) r_state <= ST_WAIT;
                        else                       r_slot  <= r_slot + 2'd1;
                    end else if (r_wdog == C_WDOG_MAX) begin
                        err_wdog   <= 1'b1;
                        freeze_clk <= 4'h0;
                        r_wdog     <= '0;
                        r_state    <= ST_IDLE;
                    end else if (w_unch && (r_slot == C_LAST_SLOT)) begin
                        r_wdog  <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (w_unch) r_slot <= r_slot + 2'd1;
                    end
                end
                ST_WAIT: begin
                    if (w_rsp_hit) begin
                        rsp_flag   <= xif.rx_payload[PAY_W-1];
                        rsp_data   <= xif.rx_payload[7:0];
                        rsp_valid  <= 1'b1;
                        freeze_clk <= 4'h0;
                        r_state    <= ST_IDLE;
                    end else if (r_wdog == C_WDOG_MAX) begin
                        err_wdog   <= 1'b1;
                        freeze_clk <= 4'h0;
                        r_wdog     <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cs_init_xchg.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_init_xchg
// Purpose  : Self-checking bench for cs_init_xchg (WDOG_MAX=20). A transaction-
//            level model predicts the ordered tx beats and responses. A
//            per-cycle compare branch checks them, and directed scenarios pin
//            timing and flags with literal values. Honours
//            CS_INIT_SKIP_UNCHANGED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_init_xchg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_0_h = 1'b0;
    logic       wen0 = 0, wen1 = 0, wen2 = 0;
    logic [7:0] i_data0 = 0, i_data1 = 0, i_data2 = 0;
    logic [3:0] freeze_clk;
    logic       rsp_valid, rsp_flag, busy, err_wdog, err_ovr;
    logic [7:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    logic [10:0] exp_tx [$];   // {idx, payload} in required order
    logic [8:0]  exp_rsp [$];  // {flag, data}
`ifdef CS_INIT_SKIP_UNCHANGED_EN
    logic [8:0]  model_last [3];
`endif

    cs_init_xchg_if #(.PAY_W(9)) xif ();

    cs_init_xchg #(.PAY_W(9), .WDOG_MAX(20), .WDOG_W(14)) dut (
        .clk_i(clk), .rst_i(rst), .clk_0_h(clk_0_h),
        .wen0(wen0), .wen1(wen1), .wen2(wen2),
        .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
        .xif(xif), .freeze_clk(freeze_clk), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy),
        .err_wdog(err_wdog), .err_ovr(err_ovr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slot payload is {wen, data}; skip mode only expects changed slots.
    task automatic model_edge(input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2);
        logic [8:0] p [3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        for (int i = 0; i < 3; i++) begin
`ifdef CS_INIT_SKIP_UNCHANGED_EN
            if (p[i] != model_last[i]) begin
                exp_tx.push_back({2'(i), p[i]});
                model_last[i] = p[i];
            end
`else
            exp_tx.push_back({2'(i), p[i]});
`endif
        end
    endtask

    task automatic set_in(input logic [8:0] p0, input logic [8:0] p1, input logic [8:0] p2);
        {wen0, i_data0} = p0;
        {wen1, i_data1} = p1;
        {wen2, i_data2} = p2;
    endtask

    task automatic model_reset();
        exp_tx.delete();
        exp_rsp.delete();
`ifdef CS_INIT_SKIP_UNCHANGED_EN
        for (int i = 0; i < 3; i++) model_last[i] = 9'h000;
`endif
    endtask

    task automatic send_rsp(input logic [1:0] idx, input logic [8:0] p);
        xif.rx_valid = 1'b1; xif.rx_idx = idx; xif.rx_payload = p;
        if (idx == 2'd3) exp_rsp.push_back(p);
        tick();
        xif.rx_valid = 1'b0; xif.rx_idx = 2'd0; xif.rx_payload = 9'h000;
    endtask

    task automatic wait_rx_ready(input string nm, output int n);
        n = 0;
        while (!xif.rx_ready && n < 100) begin tick(); n++; end
        check(nm, 32'(xif.rx_ready), 32'd1);
    endtask

    task automatic wait_tx_valid(input string nm);
        int n = 0;
        while (!xif.tx_valid && n < 100) begin tick(); n++; end
        check(nm, 32'(xif.tx_valid), 32'd1);
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_tx_valid"}, 32'(xif.tx_valid), 0);
        check({pfx, "_tx_payload"}, 32'(xif.tx_payload), 0);
        check({pfx, "_rx_ready"}, 32'(xif.rx_ready), 0);
        check({pfx, "_freeze"}, 32'(freeze_clk), 0);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({pfx, "_rsp_data"}, 32'(rsp_data), 0);
        check({pfx, "_rsp_flag"}, 32'(rsp_flag), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_err_wdog"}, 32'(err_wdog), 0);
        check({pfx, "_err_ovr"}, 32'(err_ovr), 0);
    endtask

    initial begin
        int n;
        int hs0;
        xif.tx_ready = 1'b0; xif.rx_valid = 1'b0; xif.rx_idx = 2'd0; xif.rx_payload = 9'h000;
        model_reset();
        fork
            // ---------------- per-cycle compare against the model ----------
            begin
                logic        stall_q = 1'b0;
                logic [10:0] stall_v = '0;
                logic [10:0] e;
                logic [8:0]  r;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        stall_q = 1'b0;
                    end else begin
                        check("freeze_vs_busy", 32'(freeze_clk), 32'({4{busy}}));
                        if (stall_q)
                            check("tx_hold", 32'({xif.tx_valid, xif.tx_idx, xif.tx_payload}),
                                  32'({1'b1, stall_v}));
                        if (xif.tx_valid && xif.tx_ready) begin
                            hs_count++;
                            if (exp_tx.size() == 0) begin
                                check("tx_unexpected", 32'({xif.tx_idx, xif.tx_payload}), 32'h7FF);
                            end else begin
                                e = exp_tx.pop_front();
                                check("tx_beat", 32'({xif.tx_idx, xif.tx_payload}), 32'(e));
                            end
                        end
                        stall_q = xif.tx_valid && !xif.tx_ready;
                        stall_v = {xif.tx_idx, xif.tx_payload};
                        if (rsp_valid) begin
                            if (exp_rsp.size() == 0) begin
                                check("rsp_unexpected", 32'({rsp_flag, rsp_data}), 32'h3FF);
                            end else begin
                                r = exp_rsp.pop_front();
                                check("rsp_value", 32'({rsp_flag, rsp_data}), 32'(r));
                            end
                        end
                        if (xif.rx_ready)
                            check("rx_ready_state", 32'({busy, xif.tx_valid}), 32'b10);
                    end
                end
            end
            // ---------------- directed scenarios ----------------------------
            begin
                tick(); tick(); tick();
                check_cleared("reset");
                rst = 1'b0;
                tick();

                // T1: basic transaction, slot payloads 1A5/000/000
                xif.tx_ready = 1'b1;
                set_in(9'h1A5, 9'h000, 9'h000);
                model_edge(9'h1A5, 9'h000, 9'h000);
                hs0 = hs_count;
                clk_0_h = 1'b1;
`ifndef CS_INIT_SKIP_UNCHANGED_EN
                @(negedge clk); check("t1_pre_valid", 32'(xif.tx_valid), 0);
                @(negedge clk); check("t1_edge_valid", 32'(xif.tx_valid), 0);
                check("t1_edge_busy", 32'(busy), 0);
                @(negedge clk); check("t1_slot0", 32'({xif.tx_valid, xif.tx_idx, xif.tx_payload}), 32'h0_1A5 | 32'h800);
                check("t1_freeze", 32'(freeze_clk), 32'hF);
                @(negedge clk); check("t1_slot1", 32'({xif.tx_valid, xif.tx_idx, xif.tx_payload}), 32'h800 | 32'h200);
                @(negedge clk); check("t1_slot2", 32'({xif.tx_valid, xif.tx_idx, xif.tx_payload}), 32'h800 | 32'h400);
                @(negedge clk); check("t1_wait", 32'({xif.rx_ready, xif.tx_valid}), 32'b10);
                tick();
`else
                wait_rx_ready("t1_wait", n);
`endif
                clk_0_h = 1'b0;
`ifdef CS_INIT_SKIP_UNCHANGED_EN
                check("t1_hs", 32'(hs_count - hs0), 1);
`else
                check("t1_hs", 32'(hs_count - hs0), 3);
`endif
                send_rsp(2'd3, 9'h13C);
                check("t1_rsp", 32'({rsp_valid, rsp_flag, rsp_data}), 32'h33C);
                check("t1_done", 32'({freeze_clk, busy}), 0);
                tick();
                check("t1_pulse_once", 32'(rsp_valid), 0);

                // T2: back-pressure on slot 1 for five cycles
                xif.tx_ready = 1'b0;
                set_in(9'h011, 9'h122, 9'h133);
                model_edge(9'h011, 9'h122, 9'h133);
                clk_0_h = 1'b1;
                wait_tx_valid("t2_start");
                clk_0_h = 1'b0;
                check("t2_slot0", 32'({xif.tx_idx, xif.tx_payload}), 32'h011);
                xif.tx_ready = 1'b1; tick(); xif.tx_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    check("t2_hold1", 32'({xif.tx_valid, xif.tx_idx, xif.tx_payload}), 32'h800 | 32'h200 | 32'h122);
                end
                xif.tx_ready = 1'b1; tick();
                check("t2_slot2", 32'({xif.tx_idx, xif.tx_payload}), 32'h400 | 32'h133);
                tick();
                check("t2_wait", 32'(xif.rx_ready), 1);
                send_rsp(2'd3, 9'h0AA);
                check("t2_rsp", 32'({rsp_flag, rsp_data}), 32'h0AA);
                tick();

                // T3: overrun during SEND, then a wrong-index response
                xif.tx_ready = 1'b0;
                set_in(9'h101, 9'h002, 9'h103);
                model_edge(9'h101, 9'h002, 9'h103);
                hs0 = hs_count;
                clk_0_h = 1'b1;
                wait_tx_valid("t3_start");
                clk_0_h = 1'b0; tick();
                clk_0_h = 1'b1; tick(); tick();
                clk_0_h = 1'b0;
                check("t3_err_ovr", 32'(err_ovr), 1);
                check("t3_still_slot0", 32'({xif.tx_valid, xif.tx_idx}), 32'b100);
                xif.tx_ready = 1'b1;
                wait_rx_ready("t3_wait", n);
                check("t3_hs", 32'(hs_count - hs0), 3);
                send_rsp(2'd1, 9'h1FF);
                check("t3_idx1_ignored", 32'({busy, rsp_valid, xif.rx_ready}), 32'b101);
                send_rsp(2'd3, 9'h155);
                check("t3_rsp", 32'({rsp_valid, rsp_flag, rsp_data}), 32'h355);
                tick(); tick();
                check("t3_hs_final", 32'(hs_count - hs0), 3);
                check("t3_sticky", 32'({busy, err_ovr}), 32'b01);

                // T4: no response; timeout detected in the 21st WAIT_RSP cycle
                set_in(9'h044, 9'h055, 9'h066);
                model_edge(9'h044, 9'h055, 9'h066);
                clk_0_h = 1'b1;
                wait_rx_ready("t4_wait", n);
                clk_0_h = 1'b0;
                for (int i = 0; i < 20; i++) tick();
                check("t4_cycle21", 32'({err_wdog, busy}), 32'b01);
                tick();
                check("t4_err_wdog", 32'(err_wdog), 1);
                check("t4_idle", 32'({busy, freeze_clk, xif.rx_ready, xif.tx_valid}), 0);

                // T5: async reset mid-SEND with clk_0_h held high across release
                xif.tx_ready = 1'b0;
                set_in(9'h177, 9'h188, 9'h099);
                clk_0_h = 1'b1;
                wait_tx_valid("t5_start");
                rst = 1'b1;
                #1;
                model_reset();
                check_cleared("midreset");
                tick(); tick();
                rst = 1'b0;
                model_edge(9'h177, 9'h188, 9'h099);
                hs0 = hs_count;
                xif.tx_ready = 1'b1;
                wait_rx_ready("t5_wait", n);
                check("t5_hs", 32'(hs_count - hs0), 3);
                send_rsp(2'd3, 9'h001);
                tick(); tick(); tick();
                check("t5_single_edge", 32'({busy, 8'(hs_count - hs0)}), 32'h003);
                clk_0_h = 1'b0;
                tick();

`ifdef CS_INIT_SKIP_UNCHANGED_EN
                // T6: identical inputs skip straight to WAIT_RSP
                hs0 = hs_count;
                clk_0_h = 1'b1;
                wait_rx_ready("t6_wait", n);
                check("t6_direct_wait", 32'(n), 2);
                check("t6_hs", 32'(hs_count - hs0), 0);
                clk_0_h = 1'b0;
                send_rsp(2'd3, 9'h1EE);
                tick();
                // Only slot 1 changes: one beat, two skip cycles
                set_in(9'h177, 9'h0C3, 9'h099);
                model_edge(9'h177, 9'h0C3, 9'h099);
                hs0 = hs_count;
                clk_0_h = 1'b1;
                wait_rx_ready("t6b_wait", n);
                check("t6b_cycles", 32'(n), 5);
                check("t6b_hs", 32'(hs_count - hs0), 1);
                clk_0_h = 1'b0;
                send_rsp(2'd3, 9'h012);
                tick();
`endif
                check("tx_queue_drained", 32'(exp_tx.size()), 0);
                check("rsp_queue_drained", 32'(exp_rsp.size()), 0);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
